// File: rtl/nios_timer_pkg.sv
// ============================================================================
// Module      : nios_timer_pkg
// Description : Shared constants for the multi-channel interval timer:
//               per-channel word offsets, control/status bit positions and
//               channel-count limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios_timer_pkg;

    // Word offsets within one channel's 8-word window
    localparam logic [2:0] OFS_STATUS    = 3'd0;
    localparam logic [2:0] OFS_CONTROL   = 3'd1;
    localparam logic [2:0] OFS_PERIOD_LO = 3'd2;
    localparam logic [2:0] OFS_PERIOD_HI = 3'd3;
    localparam logic [2:0] OFS_SNAP_LO   = 3'd4;
    localparam logic [2:0] OFS_SNAP_HI   = 3'd5;
    localparam logic [2:0] OFS_PRESCALE  = 3'd6;
    localparam logic [2:0] OFS_RESERVED  = 3'd7;

    // STATUS bit positions
    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    // CONTROL bit positions (START/STOP are strobes, never stored)
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // Address layout: low bits select the word, upper bits the channel
    localparam int WORD_SEL_W = 3;
    localparam int MAX_CH     = 8;

endpackage

`default_nettype wire

// File: rtl/nios_multi_interval_timer_if.sv
// ============================================================================
// Module      : nios_multi_interval_timer_if
// Description : Avalon-MM slave bus plus interrupt lines of the
//               multi-channel interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nios_multi_interval_timer_if
    import nios_timer_pkg::*;
#(
    parameter int NUM_CH = 4
) ();
    localparam int ADDR_W = $clog2(NUM_CH) + WORD_SEL_W;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq, irq_any
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq, irq_any
    );
endinterface

`default_nettype wire

// File: rtl/nios_timer_channel.sv
// ============================================================================
// Module      : nios_timer_channel
// Description : One interval-timer channel: down-counter with period reload,
//               one-shot/continuous mode, snapshot capture, timeout flag and
//               interrupt. Optional clock prescaler when the macro
//               NIOS_TIMER_PRESCALER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_timer_channel
    import nios_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [2:0]  ofs,
    input  logic [31:0] wdata,
    output logic        run,
    output logic        to,
    output logic        cont,
    output logic        ito,
    output logic        irq,
    output logic [63:0] period_q,
    output logic [63:0] snap_q
`ifdef NIOS_TIMER_PRESCALER_EN
    ,
    output logic [15:0] prescale_q
`endif
);

    localparam logic [CNT_W-1:0] C_RESET_PERIOD = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_snap;
    logic [CNT_W-1:0] w_period_new;
    logic [63:0]      w_period_ext;
    logic             r_run;
    logic             r_to;
    logic             r_cont;
    logic             r_ito;
    logic             w_wr_status;
    logic             w_wr_control;
    logic             w_wr_plo;
    logic             w_wr_phi;
    logic             w_wr_snap;
    logic             w_start;
    logic             w_stop;
    logic             w_period_wr;
    logic             w_tick;
    logic             w_expire;

    assign w_wr_status  = wr && (ofs == OFS_STATUS);
    assign w_wr_control = wr && (ofs == OFS_CONTROL);
    assign w_wr_plo     = wr && (ofs == OFS_PERIOD_LO);
    assign w_wr_phi     = wr && (ofs == OFS_PERIOD_HI);
    assign w_wr_snap    = wr && ((ofs == OFS_SNAP_LO) || (ofs == OFS_SNAP_HI));
    assign w_start      = w_wr_control && wdata[CTL_START];
    assign w_stop       = w_wr_control && wdata[CTL_STOP];
    // The high period word only exists for counters wider than 32 bits
    assign w_period_wr  = w_wr_plo || (w_wr_phi && (CNT_W > 32));
    assign w_expire     = w_tick && (r_count == '0);

    // Merge the written word into a 64-bit view of the period; bits above
    // CNT_W fall away on truncation, so narrow counters ignore HI writes
    always_comb begin
        w_period_ext = 64'(r_period);
        if (w_wr_plo) w_period_ext[31:0]  = wdata;
        if (w_wr_phi) w_period_ext[63:32] = wdata;
        w_period_new = w_period_ext[CNT_W-1:0];
    end

`ifdef NIOS_TIMER_PRESCALER_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;

    // >= rather than == so a smaller divider written mid-count cannot stall
    assign w_tick = r_run && (r_pre_cnt >= r_prescale);

    // Prescaler divider register and free-running divide counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_pre_cnt  <= '0;
        end else begin
            if (wr && (ofs == OFS_PRESCALE)) r_prescale <= wdata[15:0];
            if (w_period_wr || w_start)      r_pre_cnt  <= '0;
            else if (w_tick)                 r_pre_cnt  <= '0;
            else if (r_run)                  r_pre_cnt  <= r_pre_cnt + 16'd1;
        end
    end

    assign prescale_q = r_prescale;
`else
    assign w_tick = r_run;
`endif

    // Period register and down-counter; a period write overrides any reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= C_RESET_PERIOD;
            r_count  <= C_RESET_PERIOD;
        end else if (w_period_wr) begin
            r_period <= w_period_new;
            r_count  <= w_period_new;
        end else if (w_tick) begin
            r_count  <= (r_count == '0) ? r_period : r_count - 1'b1;
        end
    end

    // Run/timeout flags and stored control bits; START beats STOP, TO set beats clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run  <= 1'b0;
            r_to   <= 1'b0;
            r_cont <= 1'b0;
            r_ito  <= 1'b0;
        end else begin
            if (w_start)                     r_run <= 1'b1;
            else if (w_stop || w_period_wr)  r_run <= 1'b0;
            else if (w_expire && !r_cont)    r_run <= 1'b0;

            if (w_expire)                    r_to <= 1'b1;
            else if (w_wr_status)            r_to <= 1'b0;

            if (w_wr_control) begin
                r_cont <= wdata[CTL_CONT];
                r_ito  <= wdata[CTL_ITO];
            end
        end
    end

    // Snapshot captures the registered count on a write to either SNAP word
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_snap <= '0;
        else if (w_wr_snap) r_snap <= r_count;
    end

    assign run      = r_run;
    assign to       = r_to;
    assign cont     = r_cont;
    assign ito      = r_ito;
    assign irq      = r_to && r_ito;
    assign period_q = 64'(r_period);
    assign snap_q   = 64'(r_snap);

endmodule

`default_nettype wire

// File: rtl/nios_multi_interval_timer.sv
// ============================================================================
// Module      : nios_multi_interval_timer
// Description : NUM_CH independent interval timers behind a 32-bit Avalon-MM
//               slave. Holds the address decode, registered read mux and the
//               combined interrupt. Optional per-channel prescaler enabled by
//               defining NIOS_TIMER_PRESCALER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_multi_interval_timer
    import nios_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                         clk,
    input  logic                         reset,
    nios_multi_interval_timer_if.slave   bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [31:0]       w_ch_idx;
    logic [CH_W-1:0]   w_ch_sel;
    logic [2:0]        w_ofs;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic [31:0]       r_readdata;
    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_to;
    logic [NUM_CH-1:0] w_cont;
    logic [NUM_CH-1:0] w_ito;
    logic [NUM_CH-1:0] w_irq;
    logic [63:0]       w_period [NUM_CH];
    logic [63:0]       w_snap   [NUM_CH];
`ifdef NIOS_TIMER_PRESCALER_EN
    logic [15:0]       w_prescale [NUM_CH];
`endif

    assign w_ch_idx = 32'(bus.address) >> WORD_SEL_W;
    assign w_ch_sel = w_ch_idx[CH_W-1:0];
    assign w_ofs    = bus.address[2:0];
    assign w_wr     = bus.chipselect && !bus.write_n;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            nios_timer_channel #(
                .CNT_W        (CNT_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .wr         (w_wr && (w_ch_idx == 32'(i))),
                .ofs        (w_ofs),
                .wdata      (bus.writedata),
                .run        (w_run[i]),
                .to         (w_to[i]),
                .cont       (w_cont[i]),
                .ito        (w_ito[i]),
                .irq        (w_irq[i]),
                .period_q   (w_period[i]),
                .snap_q     (w_snap[i])
`ifdef NIOS_TIMER_PRESCALER_EN
                ,
                .prescale_q (w_prescale[i])
`endif
            );
        end
    endgenerate

    // Read mux: unimplemented channels and words return zero
    always_comb begin
        w_rdata = '0;
        if (w_ch_idx < 32'(NUM_CH)) begin
            case (w_ofs)
                OFS_STATUS: begin
                    w_rdata[ST_RUN] = w_run[w_ch_sel];
                    w_rdata[ST_TO]  = w_to[w_ch_sel];
                end
                OFS_CONTROL: begin
                    w_rdata[CTL_CONT] = w_cont[w_ch_sel];
                    w_rdata[CTL_ITO]  = w_ito[w_ch_sel];
                end
                OFS_PERIOD_LO: w_rdata = w_period[w_ch_sel][31:0];
                OFS_PERIOD_HI: w_rdata = w_period[w_ch_sel][63:32];
                OFS_SNAP_LO:   w_rdata = w_snap[w_ch_sel][31:0];
                OFS_SNAP_HI:   w_rdata = w_snap[w_ch_sel][63:32];
`ifdef NIOS_TIMER_PRESCALER_EN
                OFS_PRESCALE:  w_rdata = {16'd0, w_prescale[w_ch_sel]};
`endif
                default:       w_rdata = '0;
            endcase
        end
    end

    // Registered read data, one cycle after the address is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_readdata <= '0;
        else       r_readdata <= bus.chipselect ? w_rdata : 32'd0;
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = w_irq;
    assign bus.irq_any  = |w_irq;

endmodule

`default_nettype wire
